aux_cmd_engine: RTL and testbench

Command/response engine on the CalPC side that drives the `aux_io` control interface as its initiator. It issues `read_req` to pull framed command messages from the host, delivers header and payload to user logic, then frames the user's response and pushes it back through `write_req`. Traffic is strictly half-duplex: one host command, then one response. This avoids starving writes behind an `aux_io` read that blocks until host data arrives.

---
 rtl/aux_pkg.sv | 35 +++
 rtl/aux_csum_acc.sv | 28 ++
 rtl/aux_cmd_engine.sv | 207 ++++++++++++++++++++
 tb/tb_aux_cmd_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// Shared definitions for the aux_io command/response engine: header layout,
// NAK codes, engine states and the header record.
package aux_pkg;

   localparam int HDR_TYPE_LSB = 24;
   localparam int HDR_SEQ_LSB  = 16;
   localparam int HDR_LEN_LSB  = 0;

   localparam logic [7:0] NAK_CSUM    = 8'hFE;
   localparam logic [7:0] NAK_TIMEOUT = 8'hFD;

   typedef enum logic [2:0] {
      RX_HDR,
      RX_PAY,
      RX_DROP,
      RX_CSUM,
      RESP_WAIT,
      TX_HDR,
      TX_PAY,
      TX_CSUM
   } aux_state_t;

   typedef struct packed {
      logic [7:0]  kind;
      logic [7:0]  seq;
      logic [15:0] len;
   } aux_hdr_t;

   function automatic logic [31:0] make_hdr(input logic [7:0] kind, input logic [7:0] seq,
                                            input logic [15:0] len);
      return ({24'd0, kind} << HDR_TYPE_LSB) | ({24'd0, seq} << HDR_SEQ_LSB) |
             ({16'd0, len} << HDR_LEN_LSB);
   endfunction

endpackage

// File: rtl/aux_csum_acc.sv
// Running 32-bit frame checksum; a clear combined with an add restarts the sum
// at the given word so the header can be folded in on the same cycle.
module aux_csum_acc
   import aux_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        add_en,
   input  logic [31:0] word,
   output logic [31:0] sum
);

   logic [31:0] r_sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum <= 32'd0;
      end else if (clear) begin
         r_sum <= add_en ? word : 32'd0;
      end else if (add_en) begin
         r_sum <= r_sum + word;
      end
   end

   assign sum = r_sum;

endmodule

// File: rtl/aux_cmd_engine.sv
// Half-duplex command/response engine: pulls framed host commands through aux_io,
// hands them to user logic, then frames and writes back the user's response.
module aux_cmd_engine
   import aux_pkg::*;
#(
   parameter int MAX_LEN      = 1024,
   parameter int RESP_TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        write_req,
   output logic        read_req,
   output logic [31:0] data_write,
   input  logic [31:0] data_read,
   input  logic        busy,
   output logic        rx_hdr_valid,
   output logic [7:0]  rx_type,
   output logic [7:0]  rx_seq,
   output logic [15:0] rx_len,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [31:0] rx_data,
   output logic        rx_last,
   output logic        rx_done,
   output logic        rx_ok,
   input  logic        tx_start,
   input  logic [7:0]  tx_type,
   input  logic [15:0] tx_len,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [31:0] tx_data,
   output logic        idle
);

   localparam int TMR_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);
   localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

   aux_state_t       r_state;
   aux_hdr_t         r_hdr;
   logic             r_started, r_rd_req, r_wr_req, r_pend;
   logic [31:0]      r_data_write, r_rx_data;
   logic             r_hdr_valid, r_rx_valid, r_rx_last, r_rx_done, r_rx_ok, r_oversize;
   logic [15:0]      r_cnt, r_tx_len;
   logic [7:0]       r_tx_kind;
   logic [TMR_W-1:0] r_tmr;

   aux_hdr_t    w_hdr_in;
   logic        w_bus_free, w_done, w_rd_issue, w_wr_issue, w_tx_beat, w_oversize, w_csum_ok;
   logic        w_clr, w_add;
   logic [31:0] w_word, w_csum, w_tx_hdr;

   // One transaction at a time: a strobe is only raised when nothing is in flight.
   assign w_bus_free = r_started && !r_rd_req && !r_wr_req && !r_pend && !busy;
   assign w_done     = r_pend && !busy;
   assign w_rd_issue = w_bus_free && ((r_state == RX_HDR) || (r_state == RX_DROP) ||
                       (r_state == RX_CSUM) || ((r_state == RX_PAY) && !r_rx_valid));
   assign w_wr_issue = w_bus_free && ((r_state == TX_HDR) || (r_state == TX_CSUM));
   assign tx_ready   = w_bus_free && (r_state == TX_PAY);
   assign w_tx_beat  = tx_valid && tx_ready;
   assign w_hdr_in   = data_read;
   assign w_oversize = {1'b0, w_hdr_in.len} > MAX_LEN_W;
   assign w_csum_ok  = (data_read == w_csum) && !r_oversize;
   assign w_tx_hdr   = make_hdr(r_tx_kind, r_hdr.seq, r_tx_len);

   // The accumulator restarts on the header word of each direction.
   always_comb begin
      w_clr  = 1'b0;
      w_add  = 1'b0;
      w_word = tx_data;
      if (r_state inside {RX_HDR, RX_PAY, RX_DROP, RX_CSUM}) begin
         w_word = data_read;
         w_clr  = (r_state == RX_HDR) && w_done;
         w_add  = w_done && (r_state != RX_CSUM);
      end else if (r_state == TX_HDR) begin
         w_word = w_tx_hdr;
         w_clr  = w_wr_issue;
         w_add  = w_wr_issue;
      end else begin
         w_add  = w_tx_beat;
      end
   end

   aux_csum_acc u_csum (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (w_clr),
      .add_en (w_add),
      .word   (w_word),
      .sum    (w_csum)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= RX_HDR;
         r_hdr        <= '0;
         r_started    <= 1'b0;
         r_rd_req     <= 1'b0;
         r_wr_req     <= 1'b0;
         r_pend       <= 1'b0;
         r_data_write <= 32'd0;
         r_rx_data    <= 32'd0;
         r_hdr_valid  <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_last    <= 1'b0;
         r_rx_done    <= 1'b0;
         r_rx_ok      <= 1'b0;
         r_oversize   <= 1'b0;
         r_cnt        <= 16'd0;
         r_tx_len     <= 16'd0;
         r_tx_kind    <= 8'd0;
         r_tmr        <= '0;
      end else begin
         r_started   <= 1'b1;
         r_hdr_valid <= 1'b0;
         r_rx_done   <= 1'b0;
         r_rx_ok     <= 1'b0;
         r_rd_req    <= w_rd_issue;
         r_wr_req    <= w_wr_issue || w_tx_beat;
         if (r_rd_req || r_wr_req) begin
            r_pend <= 1'b1;
         end else if (w_done) begin
            r_pend <= 1'b0;
         end
         if (w_wr_issue) begin
            r_data_write <= (r_state == TX_HDR) ? w_tx_hdr : w_csum;
         end else if (w_tx_beat) begin
            r_data_write <= tx_data;
         end
         case (r_state)
            RX_HDR: if (w_done) begin
               r_hdr       <= w_hdr_in;
               r_hdr_valid <= 1'b1;
               r_cnt       <= 16'd0;
               r_oversize  <= w_oversize;
               if (w_hdr_in.len == 16'd0) r_state <= RX_CSUM;
               else if (w_oversize)       r_state <= RX_DROP;
               else                       r_state <= RX_PAY;
            end
            RX_PAY: if (w_done) begin
               r_rx_data  <= data_read;
               r_rx_valid <= 1'b1;
               r_rx_last  <= (r_cnt + 16'd1) == r_hdr.len;
               r_cnt      <= r_cnt + 16'd1;
            end else if (r_rx_valid && rx_ready) begin
               r_rx_valid <= 1'b0;
               r_rx_last  <= 1'b0;
               if (r_rx_last) r_state <= RX_CSUM;
            end
            RX_DROP: if (w_done) begin
               r_cnt <= r_cnt + 16'd1;
               if ((r_cnt + 16'd1) == r_hdr.len) r_state <= RX_CSUM;
            end
            RX_CSUM: if (w_done) begin
               r_rx_done <= 1'b1;
               r_rx_ok   <= w_csum_ok;
               r_tmr     <= '0;
               if (w_csum_ok) begin
                  r_state <= RESP_WAIT;
               end else begin
                  r_tx_kind <= NAK_CSUM;
                  r_tx_len  <= 16'd0;
                  r_state   <= TX_HDR;
               end
            end
            // A start arriving in the final timeout cycle still wins over the NAK.
            RESP_WAIT: if (tx_start) begin
               r_tx_kind <= tx_type;
               r_tx_len  <= tx_len;
               r_state   <= TX_HDR;
            end else if (r_tmr == TMR_LAST) begin
               r_tx_kind <= NAK_TIMEOUT;
               r_tx_len  <= 16'd0;
               r_state   <= TX_HDR;
            end else begin
               r_tmr <= r_tmr + TMR_W'(1);
            end
            TX_HDR: if (w_done) begin
               r_cnt   <= 16'd0;
               r_state <= (r_tx_len == 16'd0) ? TX_CSUM : TX_PAY;
            end
            TX_PAY: if (w_tx_beat) begin
               r_cnt <= r_cnt + 16'd1;
            end else if (w_done && (r_cnt == r_tx_len)) begin
               r_state <= TX_CSUM;
            end
            TX_CSUM: if (w_done) r_state <= RX_HDR;
            default: r_state <= RX_HDR;
         endcase
      end
   end

   assign read_req     = r_rd_req;
   assign write_req    = r_wr_req;
   assign data_write   = r_data_write;
   assign rx_hdr_valid = r_hdr_valid;
   assign rx_type      = r_hdr.kind;
   assign rx_seq       = r_hdr.seq;
   assign rx_len       = r_hdr.len;
   assign rx_valid     = r_rx_valid;
   assign rx_data      = r_rx_data;
   assign rx_last      = r_rx_last;
   assign rx_done      = r_rx_done;
   assign rx_ok        = r_rx_ok;
   assign idle         = (r_state == RX_HDR) && !r_rd_req && !r_pend;

endmodule

// File: tb/tb_aux_cmd_engine.sv
// Bench for aux_cmd_engine: a host-side aux_io model feeds framed commands, a
// frame-level reference fills expectation queues and a monitor checks DUT events.
module tb_aux_cmd_engine;
   import aux_pkg::*;

   localparam int MAX_LEN      = 16;
   localparam int RESP_TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        write_req, read_req, busy;
   logic [31:0] data_write, data_read;
   logic        rx_hdr_valid, rx_valid, rx_ready, rx_last, rx_done, rx_ok;
   logic [7:0]  rx_type, rx_seq;
   logic [15:0] rx_len;
   logic [31:0] rx_data;
   logic        tx_start, tx_valid, tx_ready, idle;
   logic [7:0]  tx_type;
   logic [15:0] tx_len;
   logic [31:0] tx_data;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] hostQ[$];
   logic [31:0] expHdr[$];
   logic [32:0] expPay[$];
   logic        expOk[$];
   logic [31:0] expWr[$];
   logic [31:0] fixRx[$];
   logic [31:0] fixTx[$];
   logic        holdReady = 1'b0;

   logic auxActive, auxRead;
   int   auxDly;

   aux_cmd_engine #(.MAX_LEN(MAX_LEN), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .write_req(write_req), .read_req(read_req),
      .data_write(data_write), .data_read(data_read), .busy(busy),
      .rx_hdr_valid(rx_hdr_valid), .rx_type(rx_type), .rx_seq(rx_seq), .rx_len(rx_len),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
      .rx_done(rx_done), .rx_ok(rx_ok), .tx_start(tx_start), .tx_type(tx_type),
      .tx_len(tx_len), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportUnexpected(input string name, input logic [63:0] actual);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h while nothing was expected", name, actual);
   endtask

   // aux_io model: busy rises on the strobe, completes after a random extra delay,
   // and a read stalls for as long as the host has nothing queued.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy      <= 1'b0;
         data_read <= 32'd0;
         auxActive <= 1'b0;
         auxRead   <= 1'b0;
         auxDly    <= 0;
      end else begin
         data_read <= 32'd0;
         if (!auxActive) begin
            if (read_req || write_req) begin
               busy      <= 1'b1;
               auxActive <= 1'b1;
               auxRead   <= read_req;
               auxDly    <= $urandom_range(0, 2);
            end
         end else if (auxDly != 0) begin
            auxDly <= auxDly - 1;
         end else if (!auxRead) begin
            busy      <= 1'b0;
            auxActive <= 1'b0;
         end else if (hostQ.size() != 0) begin
            data_read <= hostQ.pop_front();
            busy      <= 1'b0;
            auxActive <= 1'b0;
         end
      end
   end

   initial begin
      rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         rx_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: every DUT-presented event pops the matching expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (read_req || write_req) checkOutput("strobeOnFreeBus", 64'(busy), 64'd0);
         if (rx_hdr_valid) begin
            if (expHdr.size() == 0) reportUnexpected("rxHeader", 64'({rx_type, rx_seq, rx_len}));
            else checkOutput("rxHeader", 64'({rx_type, rx_seq, rx_len}), 64'(expHdr.pop_front()));
         end
         if (rx_valid && rx_ready) begin
            if (expPay.size() == 0) reportUnexpected("rxPayload", 64'({rx_last, rx_data}));
            else checkOutput("rxPayload", 64'({rx_last, rx_data}), 64'(expPay.pop_front()));
         end
         if (rx_done) begin
            if (expOk.size() == 0) reportUnexpected("rxOk", 64'(rx_ok));
            else checkOutput("rxOk", 64'(rx_ok), 64'(expOk.pop_front()));
         end
         if (write_req) begin
            if (expWr.size() == 0) reportUnexpected("writeWord", 64'(data_write));
            else checkOutput("writeWord", 64'(data_write), 64'(expWr.pop_front()));
         end
      end
   end

   task automatic flushQueues();
      hostQ.delete(); expHdr.delete(); expPay.delete(); expOk.delete(); expWr.delete();
      fixRx.delete(); fixTx.delete();
   endtask

   task automatic checkResetOutputs();
      checkOutput("resetCtrl", 64'({write_req, read_req, rx_hdr_valid, rx_valid, rx_last,
                                    rx_done, rx_ok, tx_ready, idle}), 64'd1);
      checkOutput("resetData", 64'({data_write, rx_data}), 64'd0);
      checkOutput("resetHdr", 64'({rx_type, rx_seq, rx_len}), 64'd0);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("firstReadDelayed", 64'(read_req), 64'd0);
   endtask

   // One full exchange: host frame in, expected response words out.
   task automatic applyStimulus(input logic [7:0] typ, input logic [7:0] seq, input int len,
                                input bit corrupt, input int dly, input logic [7:0] ttype,
                                input int tlen, input bit bp, input bit rstMid);
      logic [31:0] hdr, sum, word, tsum;
      logic [31:0] tpay[$];
      logic [7:0]  nak;
      bit          oversize, ok, seen;
      int          n;
      hdr = {typ, seq, 16'(len)};
      sum = hdr;
      expHdr.push_back(hdr);
      oversize = len > MAX_LEN;
      ok = !corrupt && !oversize;
      hostQ.push_back(hdr);
      for (int i = 0; i < len; i++) begin
         word = (fixRx.size() != 0) ? fixRx.pop_front() : $urandom;
         sum += word;
         hostQ.push_back(word);
         if (!oversize) expPay.push_back({(i == len - 1), word});
      end
      hostQ.push_back(corrupt ? sum + 32'd1 : sum);
      expOk.push_back(ok);
      nak = !ok ? NAK_CSUM : ((dly >= RESP_TIMEOUT) ? NAK_TIMEOUT : 8'h00);
      if (nak != 8'h00) begin
         expWr.push_back({nak, seq, 16'd0});
         expWr.push_back({nak, seq, 16'd0});
      end else begin
         tsum = {ttype, seq, 16'(tlen)};
         expWr.push_back(tsum);
         for (int i = 0; i < tlen; i++) begin
            word = (fixTx.size() != 0) ? fixTx.pop_front() : $urandom;
            tpay.push_back(word);
            tsum += word;
            expWr.push_back(word);
         end
         expWr.push_back(tsum);
      end

      if (bp) begin
         holdReady = 1'b1;
         seen = 0;
         for (int c = 0; c < 2000 && !seen; c++) begin @(posedge clk); #1; seen = rx_valid; end
         checkOutput("rxValidUnderHold", 64'(seen), 64'd1);
         n = 0;
         for (int c = 0; c < 50; c++) begin @(posedge clk); #1; if (read_req) n++; end
         checkOutput("readsWhileHeld", 64'(n), 64'd0);
         holdReady = 1'b0;
      end

      seen = 0;
      for (int c = 0; c < 5000 && !seen; c++) begin @(posedge clk); #1; seen = rx_done; end
      checkOutput("rxDoneArrived", 64'(seen), 64'd1);

      if (ok) begin
         repeat (dly) begin @(posedge clk); #1; end
         tx_start = 1'b1;
         tx_type  = ttype;
         tx_len   = 16'(tlen);
         @(posedge clk);
         #1;
         tx_start = 1'b0;
         tx_type  = 8'($urandom);
         tx_len   = 16'($urandom);
      end
      if (nak == 8'h00) begin
         for (int i = 0; i < tlen; i++) begin
            tx_valid = 1'b1;
            tx_data  = tpay[i];
            seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               @(negedge clk);
               seen = tx_ready;
               @(posedge clk);
               #1;
            end
            checkOutput("txBeatAccepted", 64'(seen), 64'd1);
            tx_valid = 1'b0;
            if (rstMid) begin
               #2;
               reset_n = 1'b0;
               #1;
               checkResetOutputs();
               flushQueues();
               repeat (3) @(posedge clk);
               releaseReset();
               return;
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         tx_valid = 1'b1;
         tx_data  = 32'hDEAD_BEEF;
         repeat (12) begin @(posedge clk); #1; end
         tx_valid = 1'b0;
      end

      seen = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin @(posedge clk); #1; seen = (expWr.size() == 0); end
      checkOutput("responseDrained", 64'(seen), 64'd1);
      repeat (6) begin @(posedge clk); #1; end
      checkOutput("rxQueuesDrained",
                  64'(expHdr.size() + expPay.size() + expOk.size() + hostQ.size()), 64'd0);
      flushQueues();
   endtask

   initial begin
      tx_start = 1'b0;
      tx_type  = 8'd0;
      tx_len   = 16'd0;
      tx_valid = 1'b0;
      tx_data  = 32'd0;
      #23;
      checkResetOutputs();
      releaseReset();

      fixRx.push_back(32'd1); fixRx.push_back(32'd2); fixRx.push_back(32'd3);
      fixTx.push_back(32'hA); fixTx.push_back(32'hB);
      applyStimulus(8'h12, 8'h07, 3, 1'b0, 2, 8'h22, 2, 1'b0, 1'b0);
      fixRx.push_back(32'd1); fixRx.push_back(32'd2); fixRx.push_back(32'd3);
      applyStimulus(8'h12, 8'h07, 3, 1'b1, 0, 8'h22, 2, 1'b0, 1'b0);
      applyStimulus(8'h01, 8'h00, 0, 1'b0, 0, 8'h33, 0, 1'b0, 1'b0);
      applyStimulus(8'h44, 8'h10, MAX_LEN, 1'b0, 1, 8'h45, 1, 1'b0, 1'b0);
      applyStimulus(8'h55, 8'h11, MAX_LEN + 1, 1'b0, 0, 8'h56, 1, 1'b0, 1'b0);
      applyStimulus(8'h66, 8'h12, 2, 1'b0, RESP_TIMEOUT, 8'h67, 2, 1'b0, 1'b0);
      applyStimulus(8'h66, 8'h13, 2, 1'b0, RESP_TIMEOUT - 1, 8'h67, 2, 1'b0, 1'b0);
      applyStimulus(8'h77, 8'h14, 4, 1'b0, 0, 8'h78, 1, 1'b1, 1'b0);
      applyStimulus(8'h88, 8'h15, 2, 1'b0, 0, 8'h89, 3, 1'b0, 1'b1);
      applyStimulus(8'h99, 8'h16, 2, 1'b0, 0, 8'h9A, 2, 1'b0, 1'b0);

      for (int f = 0; f < 12; f++) begin
         repeat (3) @(posedge clk);
         #1;
         tx_start = 1'b1;
         tx_type  = 8'($urandom);
         tx_len   = 16'($urandom);
         @(posedge clk);
         #1;
         tx_start = 1'b0;
         applyStimulus(8'($urandom), 8'($urandom), $urandom_range(0, MAX_LEN + 2),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 5), 8'($urandom),
                       $urandom_range(0, 4), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
